// File: rtl/data_mem_ctrl.sv
// Handshaked half-word data memory controller: valid/ready request channel,
// programmable wait states, 16/32-bit and stack-offset access, range-error reporting.
module data_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1048576,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic                  i_en32,
  input  logic                  i_isStack,
  input  logic [31:0]           i_address,
  input  logic [2*DATA_W-1:0]   i_data_in,
  output logic                  o_rsp_valid,
  output logic [2*DATA_W-1:0]   o_data_out,
  output logic                  o_err
);

  localparam int              FW       = 2 * DATA_W;
  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]     DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]      CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [AW-1:0]   ONE_IDX  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic [31:0]         addr_r;
  logic [FW-1:0]       wdata_r;
  logic                rd_r;
  logic                wr_r;
  logic                en32_r;
  logic                stack_r;

  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic [AW-1:0]       idx_s;
  logic [AW-1:0]       idx_hi_s;
  logic [AW-1:0]       idx_stk_s;
  logic                err_s;
  logic [FW-1:0]       rdata_s;

  // Range check on the full 32-bit address and read-data selection for the latched request
  always_comb begin
    idx_s     = addr_r[AW-1:0];
    idx_hi_s  = idx_s - ONE_IDX;
    idx_stk_s = idx_s + ONE_IDX;
    err_s     = 1'b0;
    if (rd_r || wr_r) begin
      if (addr_r >= DEPTH_W) begin
        err_s = 1'b1;
      end else if (en32_r && (addr_r == 32'd0)) begin
        err_s = 1'b1;
      end else if (rd_r && !en32_r && stack_r && ((addr_r + 32'd1) >= DEPTH_W)) begin
        err_s = 1'b1;
      end else begin
        err_s = 1'b0;
      end
    end else begin
      err_s = 1'b0;
    end
    if (en32_r) begin
      rdata_s = {mem_r[idx_hi_s], mem_r[idx_s]};
    end else if (stack_r) begin
      rdata_s = {{DATA_W{1'b0}}, mem_r[idx_stk_s]};
    end else begin
      rdata_s = {{DATA_W{1'b0}}, mem_r[idx_s]};
    end
  end

  // Array commit on the ACCESS edge; the high half of a 32-bit word lives at A-1
  always_ff @(posedge clk) begin
    if (!i_rst && (state_r == S_ACCESS) && wr_r && !err_s) begin
      if (en32_r) begin
        mem_r[idx_hi_s] <= wdata_r[FW-1:DATA_W];
        mem_r[idx_s]    <= wdata_r[DATA_W-1:0];
      end else begin
        mem_r[idx_s]    <= wdata_r[DATA_W-1:0];
      end
    end
  end

  // Request acceptance, wait-state sequencing and registered response outputs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_data_out  <= {FW{1'b0}};
      o_err       <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= {FW{1'b0}};
      rd_r        <= 1'b0;
      wr_r        <= 1'b0;
      en32_r      <= 1'b0;
      stack_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          o_rsp_valid <= 1'b0;
          o_err       <= 1'b0;
          if (i_req_valid && o_req_ready) begin
            addr_r      <= i_address;
            wdata_r     <= i_data_in;
            rd_r        <= i_memRead;
            wr_r        <= i_memWrite;
            en32_r      <= i_en32;
            stack_r     <= i_isStack;
            o_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_r <= S_ACCESS;
            end else begin
              cnt_r   <= CNT_LOAD;
              state_r <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= S_ACCESS;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_ACCESS: begin
          o_rsp_valid <= 1'b1;
          o_err       <= err_s;
          o_req_ready <= 1'b1;
          state_r     <= S_IDLE;
          // A write-only response keeps the previous read data on the bus
          if (err_s) begin
            o_data_out <= {FW{1'b0}};
          end else if (rd_r) begin
            o_data_out <= rdata_s;
          end else if (!wr_r) begin
            o_data_out <= {FW{1'b0}};
          end
        end
        default: begin
          state_r     <= S_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed requests, a transaction-level
// memory model with a response schedule, and literal checks on key results.
module tb_data_mem_ctrl;
  localparam int DW    = 16;
  localparam int FW    = 32;
  localparam int DEPTH = 1024;
  localparam int WC    = 2;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_memRead;
  logic          i_memWrite;
  logic          i_en32;
  logic          i_isStack;
  logic [31:0]   i_address;
  logic [FW-1:0] i_data_in;
  logic          o_rsp_valid;
  logic [FW-1:0] o_data_out;
  logic          o_err;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_en32(i_en32), .i_isStack(i_isStack),
    .i_address(i_address), .i_data_in(i_data_in), .o_rsp_valid(o_rsp_valid),
    .o_data_out(o_data_out), .o_err(o_err)
  );

  typedef struct {
    int            due;
    logic [FW-1:0] data;
    logic          err;
  } rsp_t;

  int            n_checks = 0;
  int            n_fail = 0;
  int            n_rsp = 0;
  int            cyc = 0;
  int            busy_until = -1;
  bit            chk_en = 1'b0;
  rsp_t          q[$];
  logic [DW-1:0] mm [DEPTH];
  logic [FW-1:0] m_dout = 32'd0;
  logic [FW-1:0] last_data = 32'd0;
  logic [FW-1:0] last_err = 32'd0;
  int            acc [3];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the scheduled model responses
  always @(negedge clk) begin : cmp
    bit ev;
    if (chk_en) begin
      chk("ready", {31'd0, o_req_ready}, {31'd0, (cyc > busy_until)});
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, ev});
      if (ev) begin
        if (o_rsp_valid) begin
          chk("rsp_data", o_data_out, q[0].data);
          chk("rsp_err", {31'd0, o_err}, {31'd0, q[0].err});
          last_data = o_data_out;
          last_err  = {31'd0, o_err};
          n_rsp++;
        end
        void'(q.pop_front());
      end
    end
  end

  // Transaction model: list the half-words a request touches, then apply the rules
  task automatic model_req(input bit rd, input bit wr, input bit e32, input bit stk,
                           input logic [31:0] addr, input logic [FW-1:0] din, input int at);
    longint a;
    longint idx[$];
    bit     err;
    rsp_t   r;
    a   = longint'({32'd0, addr});
    err = 1'b0;
    if (rd || wr) begin
      if (e32) begin
        idx.push_back(a - 1);
        idx.push_back(a);
      end else begin
        if (rd) idx.push_back(stk ? a + 1 : a);
        if (wr) idx.push_back(a);
      end
    end
    foreach (idx[i]) if (idx[i] < 0 || idx[i] >= DEPTH) err = 1'b1;
    if (err) m_dout = 32'd0;
    else if (rd) m_dout = e32 ? {mm[int'(a - 1)], mm[int'(a)]}
                              : {16'd0, mm[int'(stk ? a + 1 : a)]};
    else if (!wr) m_dout = 32'd0;
    if (wr && !err) begin
      if (e32) begin
        mm[int'(a - 1)] = din[31:16];
        mm[int'(a)]     = din[15:0];
      end else begin
        mm[int'(a)] = din[15:0];
      end
    end
    r.due = at + WC + 1;
    r.data = m_dout;
    r.err = err;
    q.push_back(r);
    busy_until = at + WC;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!o_req_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: ready %b expected 1", o_req_ready);
    end
  endtask

  // Issues one request; inputs are scrambled right after acceptance
  task automatic do_req(input bit rd, input bit wr, input bit e32, input bit stk,
                        input logic [31:0] addr, input logic [FW-1:0] din,
                        input bit mdl, input bit wait_done);
    i_memRead = rd; i_memWrite = wr; i_en32 = e32; i_isStack = stk;
    i_address = addr; i_data_in = din; i_req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_address = $urandom; i_data_in = $urandom;
    i_memRead = 1'b1; i_memWrite = 1'b1; i_en32 = 1'b1; i_isStack = 1'b1;
    if (mdl) model_req(rd, wr, e32, stk, addr, din, cyc);
    if (wait_done) wait_rsp();
  endtask

  task automatic rd_lit(input string name, input bit e32, input bit stk,
                        input logic [31:0] addr, input logic [FW-1:0] exp, input bit exp_err);
    do_req(1'b1, 1'b0, e32, stk, addr, 32'd0, 1'b1, 1'b1);
    chk(name, last_data, exp);
    chk({name, "_err"}, last_err, {31'd0, exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
    i_en32 = 1'b0; i_isStack = 1'b0; i_address = 32'd0; i_data_in = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_rsp", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_data", o_data_out, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 32-bit write/read, high half at A-1
    do_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1);
    rd_lit("rd32", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    rd_lit("rd16_hi", 1'b0, 1'b0, 32'h0F, 32'h0000DEAD, 1'b0);
    rd_lit("rd16_lo", 1'b0, 1'b0, 32'h10, 32'h0000BEEF, 1'b0);
    chk("model_0f", {16'd0, mm[15]}, 32'h0000DEAD);

    // 16-bit and stack-offset reads
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h00001234, 1'b1, 1'b1);
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 32'h00005678, 1'b1, 1'b1);
    rd_lit("rd_stack", 1'b0, 1'b1, 32'h20, 32'h00005678, 1'b0);
    rd_lit("rd_nostack", 1'b0, 1'b0, 32'h20, 32'h00001234, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 1'b1, 32'h22, 32'h00009ABC, 1'b1, 1'b1);
    rd_lit("wr_stack_ign", 1'b0, 1'b0, 32'h22, 32'h00009ABC, 1'b0);

    // Range errors
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h3FF, 32'h00007777, 1'b1, 1'b1);
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h00004242, 1'b1, 1'b1);
    rd_lit("err_rd32_a0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0000BBBB, 1'b1, 1'b1);
    chk("err_wr400", last_err, 32'd1);
    chk("err_wr400_data", last_data, 32'd0);
    rd_lit("err_stack3ff", 1'b0, 1'b1, 32'h3FF, 32'h0, 1'b1);
    do_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h11112222, 1'b1, 1'b1);
    chk("err_wr32_a0", last_err, 32'd1);
    rd_lit("keep_3ff", 1'b0, 1'b0, 32'h3FF, 32'h00007777, 1'b0);
    rd_lit("keep_000", 1'b0, 1'b0, 32'h0, 32'h00004242, 1'b0);
    rd_lit("err_big", 1'b0, 1'b0, 32'h80000000, 32'h0, 1'b1);
    do_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 32'h01020304, 1'b1, 1'b1);
    rd_lit("rd32_a1", 1'b1, 1'b0, 32'h1, 32'h01020304, 1'b0);

    // Read-before-write, write-only hold, no-op request
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0000AAAA, 1'b1, 1'b1);
    do_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h00005555, 1'b1, 1'b1);
    chk("rbw_old", last_data, 32'h0000AAAA);
    rd_lit("rbw_new", 1'b0, 1'b0, 32'h30, 32'h00005555, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0000EEEE, 1'b1, 1'b1);
    chk("wr_hold", last_data, 32'h00005555);
    do_req(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("noop_data", last_data, 32'd0);
    chk("noop_err", last_err, 32'd0);

    // Valid held high across three requests
    i_memRead = 1'b1; i_memWrite = 1'b0; i_en32 = 1'b1; i_isStack = 1'b0;
    i_address = 32'h10; i_data_in = 32'd0; i_req_valid = 1'b1;
    n_rsp = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      @(posedge clk); #1;
      acc[k] = cyc;
      if (k == 2) i_req_valid = 1'b0;
      model_req(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, cyc);
    end
    wait_rsp();
    chk("spacing01", 32'(acc[1] - acc[0]), 32'd4);
    chk("spacing12", 32'(acc[2] - acc[1]), 32'd4);
    chk("rsp_count", 32'(n_rsp), 32'd3);
    chk("hold_data", last_data, 32'hDEADBEEF);

    // Reset during WAIT abandons a write
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h00001111, 1'b1, 1'b1);
    chk_en = 1'b0;
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0000CAFE, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("mid_rst_rsp", {31'd0, o_rsp_valid}, 32'd0);
    chk("mid_rst_data", o_data_out, 32'd0);
    chk("mid_rst_err", {31'd0, o_err}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_norsp", {31'd0, o_rsp_valid}, 32'd0);
    end
    i_rst = 1'b0;
    m_dout = 32'd0;
    busy_until = -1;
    q.delete();
    @(posedge clk); #1;
    chk_en = 1'b1;
    rd_lit("rst_keep_40", 1'b0, 1'b0, 32'h40, 32'h00001111, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
